// File: rtl/posit_normalizer_if.sv
// posit_normalizer_if: valid/ready bundle between the accumulator, the normalizer and the write-back FIFO
interface posit_normalizer_if #(
  parameter int ACC_W = 128,
  parameter int SCALE_W = 10,
  parameter int N = 32
);
  logic in_valid;
  logic in_ready;
  logic [ACC_W-1:0] in_acc;
  logic [SCALE_W-1:0] in_scale;
  logic in_nar;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic [N-1:0] out_posit;
  logic out_sat;
  logic out_last;
  modport master (
    output in_valid, in_acc, in_scale, in_nar, in_last, out_ready,
    input in_ready, out_valid, out_posit, out_sat, out_last
  );
  modport slave (
    input in_valid, in_acc, in_scale, in_nar, in_last, out_ready,
    output in_ready, out_valid, out_posit, out_sat, out_last
  );
endinterface

// File: rtl/posit_normalizer.sv
// posit_normalizer: signed accumulator x 2^scale to N-bit posit, 5-stage pipeline with valid/ready.
// Macro POSIT_NORM_RNE_EN selects round-to-nearest-even; undefined gives round-half-up.
module posit_normalizer #(
  parameter int ACC_W = 128,
  parameter int SCALE_W = 10,
  parameter int N = 32,
  parameter int ES = 2
) (
  input logic clk,
  input logic rst,
  posit_normalizer_if.slave io_bus
);
  localparam int PW = $clog2(ACC_W);
  localparam int EW = SCALE_W + 2;
  localparam int KW = EW - ES;
  localparam int FW = N - 2 - ES;
  localparam logic signed [EW-1:0] EMAX = EW'((N - 2) << ES);
  localparam logic signed [EW-1:0] EMIN = -EMAX;
  logic w_en;
  logic [4:0] r_v;
  logic [N-1:0] r_posit;
  logic r_sat;
  logic r_last;
  logic r_s1_sign, r_s1_nar, r_s1_last;
  logic [ACC_W-1:0] r_s1_mag;
  logic signed [SCALE_W-1:0] r_s1_scale;
  logic [PW-1:0] w_s2_p;
  logic signed [EW-1:0] w_s2_exp;
  logic r_s2_sign, r_s2_nar, r_s2_last, r_s2_zero;
  logic [ACC_W-1:0] r_s2_mag;
  logic [PW-1:0] r_s2_p;
  logic signed [EW-1:0] r_s2_exp;
  logic signed [KW-1:0] w_s3_k;
  logic [PW-1:0] w_s3_shamt;
  logic r_s3_sign, r_s3_nar, r_s3_last, r_s3_zero, r_s3_ovf, r_s3_unf, r_s3_kneg;
  logic [KW-1:0] r_s3_rsh;
  logic [ES-1:0] r_s3_e;
  logic [FW-1:0] r_s3_frac;
`ifdef POSIT_NORM_RNE_EN
  logic r_s3_stk;
`endif
  logic [N-1:0] w_s4_v, w_s4_sh;
  logic w_s4_inc;
  logic [N-2:0] w_s4_body;
  logic r_s4_sign, r_s4_nar, r_s4_last, r_s4_zero, r_s4_ovf, r_s4_unf;
  logic [N-2:0] r_s4_body;
  logic [N-1:0] w_s5_mag, w_s5_posit;
  logic w_s5_sat;
  assign w_en = ~r_v[4] | io_bus.out_ready;
  assign io_bus.in_ready = w_en;
  assign io_bus.out_valid = r_v[4];
  assign io_bus.out_posit = r_posit;
  assign io_bus.out_sat = r_sat;
  assign io_bus.out_last = r_last;
  // Stage 1: capture the beat and take its magnitude (most negative value maps to 2^(ACC_W-1))
  always_ff @(posedge clk)
    if (w_en) begin
      r_s1_sign <= io_bus.in_acc[ACC_W-1];
      r_s1_mag <= io_bus.in_acc[ACC_W-1] ? -io_bus.in_acc : io_bus.in_acc;
      r_s1_scale <= io_bus.in_scale;
      r_s1_nar <= io_bus.in_nar;
      r_s1_last <= io_bus.in_last;
    end
  // Leading-one position of the magnitude
  always_comb begin
    w_s2_p = '0;
    for (int i = 0; i < ACC_W; i++) if (r_s1_mag[i]) w_s2_p = PW'(i);
  end
  assign w_s2_exp = EW'({1'b0, w_s2_p}) + EW'(r_s1_scale);
  // Stage 2: leading-one index, zero flag and binary exponent
  always_ff @(posedge clk)
    if (w_en) begin
      r_s2_sign <= r_s1_sign;
      r_s2_nar <= r_s1_nar;
      r_s2_last <= r_s1_last;
      r_s2_zero <= ~|r_s1_mag;
      r_s2_mag <= r_s1_mag;
      r_s2_p <= w_s2_p;
      r_s2_exp <= w_s2_exp;
    end
  assign w_s3_k = KW'(r_s2_exp >>> ES);
  assign w_s3_shamt = PW'(ACC_W - 1) - r_s2_p;
  // Stage 3: left-align the fraction, split exponent into regime k and e, flag out-of-range
  always_ff @(posedge clk)
    if (w_en) begin
      r_s3_sign <= r_s2_sign;
      r_s3_nar <= r_s2_nar;
      r_s3_last <= r_s2_last;
      r_s3_zero <= r_s2_zero;
      r_s3_ovf <= r_s2_exp > EMAX;
      r_s3_unf <= r_s2_exp < EMIN;
      r_s3_kneg <= w_s3_k[KW-1];
      r_s3_rsh <= w_s3_k[KW-1] ? ~w_s3_k : w_s3_k;
      r_s3_e <= r_s2_exp[ES-1:0];
      r_s3_frac <= FW'((r_s2_mag << w_s3_shamt) >> (ACC_W - 1 - FW));
`ifdef POSIT_NORM_RNE_EN
      r_s3_stk <= |(ACC_W - 1 - FW)'(r_s2_mag << w_s3_shamt);
`endif
    end
  // Arithmetic shift of {10|01, e, frac} replicates the marker into the regime run
  assign w_s4_v = {r_s3_kneg ? 2'b01 : 2'b10, r_s3_e, r_s3_frac};
  assign w_s4_sh = N'($signed(w_s4_v) >>> r_s3_rsh);
`ifdef POSIT_NORM_RNE_EN
  assign w_s4_inc = w_s4_sh[0] & (w_s4_sh[1] | r_s3_stk | |(w_s4_v & ~({N{1'b1}} << r_s3_rsh)));
`else
  assign w_s4_inc = w_s4_sh[0];
`endif
  assign w_s4_body = w_s4_sh[N-1:1] + (N-1)'(w_s4_inc & ~&w_s4_sh[N-1:1]);
  // Stage 4: rounded body; a carry out of maxpos is suppressed
  always_ff @(posedge clk)
    if (w_en) begin
      r_s4_sign <= r_s3_sign;
      r_s4_nar <= r_s3_nar;
      r_s4_last <= r_s3_last;
      r_s4_zero <= r_s3_zero;
      r_s4_ovf <= r_s3_ovf;
      r_s4_unf <= r_s3_unf;
      r_s4_body <= w_s4_body;
    end
  assign w_s5_mag = r_s4_ovf ? {1'b0, {(N-1){1'b1}}} : r_s4_unf ? N'(1) : {1'b0, r_s4_body};
  assign w_s5_posit = r_s4_nar ? {1'b1, (N-1)'(0)} : r_s4_zero ? '0 : r_s4_sign ? -w_s5_mag : w_s5_mag;
  assign w_s5_sat = ~r_s4_nar & ~r_s4_zero & (r_s4_ovf | r_s4_unf);
  // Valid chain and output stage; reset discards every in-flight beat
  always_ff @(posedge clk)
    if (!rst) begin
      r_v <= '0;
      r_posit <= '0;
      r_sat <= 1'b0;
      r_last <= 1'b0;
    end else if (w_en) begin
      r_v <= {r_v[3:0], io_bus.in_valid};
      r_posit <= w_s5_posit;
      r_sat <= w_s5_sat;
      r_last <= r_s4_last;
    end
endmodule

// File: tb/tb_posit_normalizer.sv
// tb_posit_normalizer: scoreboard bench for posit_normalizer (N=32, ES=2)
module tb_posit_normalizer;
  localparam int ACC_W = 128;
  localparam int SCALE_W = 10;
  localparam int N = 32;
  localparam int ES = 2;
  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [SCALE_W-1:0] scale;
    logic nar;
    logic last;
    logic [N+1:0] expv;
  } stim_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;
  stim_t stim_q[$];
  logic [N+1:0] sb[$];
  posit_normalizer_if #(.ACC_W(ACC_W), .SCALE_W(SCALE_W), .N(N)) bus();
  posit_normalizer #(.ACC_W(ACC_W), .SCALE_W(SCALE_W), .N(N), .ES(ES)) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus)
  );
  always #5 clk = ~clk;
  // Serial reference: emits regime, exponent and fraction bits one at a time; returns {sat, posit}
  function automatic logic [N:0] model(input logic [ACC_W-1:0] acc, input logic signed [SCALE_W-1:0] scale, input logic nar);
    logic sgn;
    logic [ACC_W-1:0] mag;
    logic [N-2:0] body;
    logic [N-1:0] res;
    bit g, st, b, sat, inc;
    int p, ee, k, ex, rl, tot;
    if (nar) return {1'b0, 1'b1, (N-1)'(0)};
    sgn = acc[ACC_W-1];
    mag = sgn ? -acc : acc;
    if (mag == 0) return '0;
    p = 0;
    for (int i = ACC_W - 1; i >= 0; i--) if (mag[i]) begin p = i; break; end
    ee = p + int'(scale);
    sat = 1'b0;
    if (ee > (N - 2) * 4) begin res = {1'b0, {(N-1){1'b1}}}; sat = 1'b1; end
    else if (ee < -(N - 2) * 4) begin res = N'(1); sat = 1'b1; end
    else begin
      k = ee >>> ES;
      ex = ee & 3;
      rl = (k >= 0) ? k + 2 : -k + 1;
      tot = rl + 2 + p;
      body = '0; g = 0; st = 0;
      for (int j = 0; j < tot; j++) begin
        if (j < rl) b = (k >= 0) ? (j <= k) : (j == rl - 1);
        else if (j == rl) b = ex[1];
        else if (j == rl + 1) b = ex[0];
        else b = mag[p - 1 - (j - rl - 2)];
        if (j < N - 1) body = {body[N-3:0], b};
        else if (j == N - 1) g = b;
        else st = st | b;
      end
      if (tot < N - 1) body = body << (N - 1 - tot);
`ifdef POSIT_NORM_RNE_EN
      inc = g & (st | body[0]);
`else
      inc = g;
`endif
      if (inc && body != '1) body = body + 1'b1;
      res = {1'b0, body};
    end
    if (sgn) res = -res;
    return {sat, res};
  endfunction
  function automatic void add(input logic [ACC_W-1:0] acc, input logic [SCALE_W-1:0] scale, input logic nar, input logic last, input logic [N+1:0] expv);
    stim_t s;
    s.acc = acc; s.scale = scale; s.nar = nar; s.last = last; s.expv = expv;
    stim_q.push_back(s);
  endfunction
  // One cycle: offer head of stim_q, pick out_ready, report output state, move accepted expectation to sb
  task automatic step(output logic vld, output logic rdy, output logic [N+1:0] obs);
    stim_t s;
    @(negedge clk);
    bus.in_valid = stim_q.size() != 0;
    if (stim_q.size() != 0) begin
      bus.in_acc = stim_q[0].acc;
      bus.in_scale = stim_q[0].scale;
      bus.in_nar = stim_q[0].nar;
      bus.in_last = stim_q[0].last;
    end
    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    vld = bus.out_valid;
    rdy = bus.out_ready;
    obs = {bus.out_last, bus.out_sat, bus.out_posit};
    if (bus.in_valid && bus.in_ready) begin
      s = stim_q.pop_front();
      sb.push_back(s.expv);
    end
    @(posedge clk);
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_posit !== '0) begin errors++; $display("FAIL reset out_posit: got %h expected 0", bus.out_posit); end
    checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL reset out_sat: got %b expected 0", bus.out_sat); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset out_last: got %b expected 0", bus.out_last); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready); end
  endtask
  task automatic test_latency;
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_acc = 128'd1; bus.in_scale = '0; bus.in_nar = 1'b0; bus.in_last = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 20) begin @(posedge clk); lat++; #1; end
    checks++; if (lat != 5) begin errors++; $display("FAIL latency: got %0d cycles expected 5", lat); end
    checks++; if ({bus.out_last, bus.out_sat, bus.out_posit} !== {2'b10, 32'h4000_0000}) begin
      errors++; $display("FAIL latency value: got %h expected %h", {bus.out_last, bus.out_sat, bus.out_posit}, {2'b10, 32'h4000_0000});
    end
    @(negedge clk);
  endtask
  task automatic test_basic;
    logic v, r;
    logic [N+1:0] o, e;
    add(128'd1, 10'd0, 1'b0, 1'b0, {2'b00, 32'h4000_0000});
    add({ACC_W{1'b1}}, 10'd0, 1'b0, 1'b0, {2'b00, 32'hC000_0000});
    add(128'd3, 10'h3FF, 1'b0, 1'b0, {2'b00, 32'h4400_0000});
    add(128'd0, 10'd5, 1'b0, 1'b0, {2'b00, 32'h0000_0000});
    add({1'b1, 127'd0}, 10'(-127), 1'b0, 1'b1, {2'b10, 32'hC000_0000});
    for (int c = 0; c < 100 && (stim_q.size() != 0 || sb.size() != 0); c++) begin
      step(v, r, o);
      if (v && r) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL basic extra beat: got %h expected none", o); end
        else begin e = sb.pop_front(); if (o !== e) begin errors++; $display("FAIL basic: got %h expected %h", o, e); end end
      end
    end
    checks++; if (stim_q.size() + sb.size() != 0) begin errors++; $display("FAIL basic timeout: got %0d outstanding expected 0", stim_q.size() + sb.size()); end
  endtask
  task automatic test_specials;
    logic v, r;
    logic [N+1:0] o, e;
    add(128'd5, 10'd0, 1'b1, 1'b0, {2'b00, 32'h8000_0000});
    add(128'd1, 10'd200, 1'b0, 1'b0, {2'b01, 32'h7FFF_FFFF});
    add(128'd1, 10'(-200), 1'b0, 1'b0, {2'b01, 32'h0000_0001});
    add({ACC_W{1'b1}}, 10'd200, 1'b0, 1'b0, {2'b01, 32'h8000_0001});
    add(128'd0, 10'd300, 1'b0, 1'b0, {2'b00, 32'h0000_0000});
    add(128'd1, 10'd120, 1'b0, 1'b0, {2'b00, 32'h7FFF_FFFF});
    add(128'd1, 10'(-120), 1'b0, 1'b0, {2'b00, 32'h0000_0001});
    for (int c = 0; c < 100 && (stim_q.size() != 0 || sb.size() != 0); c++) begin
      step(v, r, o);
      if (v && r) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL specials extra beat: got %h expected none", o); end
        else begin e = sb.pop_front(); if (o !== e) begin errors++; $display("FAIL specials: got %h expected %h", o, e); end end
      end
    end
    checks++; if (stim_q.size() + sb.size() != 0) begin errors++; $display("FAIL specials timeout: got %0d outstanding expected 0", stim_q.size() + sb.size()); end
  endtask
  task automatic test_rounding;
    logic v, r;
    logic [N+1:0] o, e;
`ifdef POSIT_NORM_RNE_EN
    add(128'h1000_0001, 10'(-28), 1'b0, 1'b0, {2'b00, 32'h4000_0000});
`else
    add(128'h1000_0001, 10'(-28), 1'b0, 1'b0, {2'b00, 32'h4000_0001});
`endif
    add(128'h1000_0003, 10'(-28), 1'b0, 1'b0, {2'b00, 32'h4000_0002});
    add(-128'h1000_0003, 10'(-28), 1'b0, 1'b0, {2'b00, 32'hBFFF_FFFE});
    for (int c = 0; c < 100 && (stim_q.size() != 0 || sb.size() != 0); c++) begin
      step(v, r, o);
      if (v && r) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rounding extra beat: got %h expected none", o); end
        else begin e = sb.pop_front(); if (o !== e) begin errors++; $display("FAIL rounding: got %h expected %h", o, e); end end
      end
    end
    checks++; if (stim_q.size() + sb.size() != 0) begin errors++; $display("FAIL rounding timeout: got %0d outstanding expected 0", stim_q.size() + sb.size()); end
  endtask
  task automatic test_backpressure;
    logic v, r, pstall;
    logic [N+1:0] o, e, po;
    logic [ACC_W-1:0] acc;
    logic [SCALE_W-1:0] scale;
    logic nar;
    for (int i = 0; i < 20; i++) begin
      acc = {$urandom(), $urandom(), $urandom(), $urandom()} >> $urandom_range(0, 127);
      if ($urandom_range(0, 1) == 1) acc = -acc;
      if (i == 11) acc = '0;
      scale = 10'($urandom_range(0, 280)) - 10'd140;
      nar = (i == 7);
      add(acc, scale, nar, i == 19, {i == 19, model(acc, $signed(scale), nar)});
    end
    rand_ready = 1'b1;
    pstall = 1'b0;
    po = '0;
    for (int c = 0; c < 400 && (stim_q.size() != 0 || sb.size() != 0); c++) begin
      step(v, r, o);
      if (pstall) begin
        checks++;
        if (!v || o !== po) begin errors++; $display("FAIL stall hold: got valid=%b %h expected valid=1 %h", v, o, po); end
      end
      pstall = v && !r;
      po = o;
      if (v && r) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL stream extra beat: got %h expected none", o); end
        else begin e = sb.pop_front(); if (o !== e) begin errors++; $display("FAIL stream: got %h expected %h", o, e); end end
      end
    end
    rand_ready = 1'b0;
    checks++; if (stim_q.size() + sb.size() != 0) begin errors++; $display("FAIL stream timeout: got %0d outstanding expected 0", stim_q.size() + sb.size()); end
    for (int c = 0; c < 8; c++) begin
      step(v, r, o);
      checks++; if (v) begin errors++; $display("FAIL stream duplicate: got beat %h expected none", o); end
    end
  endtask
  task automatic test_reset_midstream;
    logic v, r;
    logic [N+1:0] o;
    int lat;
    add(128'd5, 10'd0, 1'b0, 1'b0, '0);
    add(128'd7, 10'd0, 1'b0, 1'b0, '0);
    add(128'd9, 10'd0, 1'b0, 1'b1, '0);
    for (int c = 0; c < 3; c++) step(v, r, o);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid: got %b expected 0", bus.out_valid); end
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    stim_q.delete();
    for (int c = 0; c < 10; c++) begin
      step(v, r, o);
      checks++; if (v) begin errors++; $display("FAIL midreset stale beat: got %h expected none", o); end
    end
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_acc = 128'd3; bus.in_scale = 10'h3FF; bus.in_nar = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk);
    lat = 1;
    #1 bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 20) begin @(posedge clk); lat++; #1; end
    checks++; if (lat != 5) begin errors++; $display("FAIL midreset latency: got %0d cycles expected 5", lat); end
    checks++; if (bus.out_posit !== 32'h4400_0000) begin errors++; $display("FAIL midreset value: got %h expected 44000000", bus.out_posit); end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_acc = '0;
    bus.in_scale = '0;
    bus.in_nar = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    test_reset;
    test_latency;
    test_basic;
    test_specials;
    test_rounding;
    test_backpressure;
    test_reset_midstream;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
